// File: rtl/noc_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_defs : definitions shared by the router input and output blocks  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package noc_defs;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int N_ADD          = 2;
   localparam int DEST_X_LSB     = 0;
   localparam int DEST_Y_LSB     = N_ADD;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } flow_state_e;

   function automatic logic [N_ADD-1:0] dest_x(input logic [DEF_DATA_WIDTH-1:0] flit);
      return flit[DEST_X_LSB +: N_ADD];
   endfunction

   function automatic logic [N_ADD-1:0] dest_y(input logic [DEF_DATA_WIDTH-1:0] flit);
      return flit[DEST_Y_LSB +: N_ADD];
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_flow_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_flow_control : IDLE/SEND link FSM, stall counter and blocked  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module output_flow_control
   import noc_defs::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int STALL_W     = 8,
   parameter int STALL_LIMIT = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_avail,
   input  logic [DATA_WIDTH-1:0] i_head,
   input  logic                  i_ret,
   output logic                  o_pop,
   output logic                  o_val,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_blocked
);

   localparam logic [STALL_W-1:0] c_stall_max   = '1;
   localparam logic [STALL_W-1:0] c_stall_limit = STALL_W'(STALL_LIMIT);
   localparam logic [STALL_W-1:0] c_stall_one   = STALL_W'(1);

   flow_state_e         r_state;
   logic                r_val;
   logic [DATA_WIDTH-1:0] r_data;
   logic [STALL_W-1:0]  r_stall;
   logic                r_blocked;
   logic [STALL_W-1:0]  w_stall_next;

   // ret only matters while a flit is being offered
   assign o_pop = i_avail && ((r_state == IDLE) || i_ret);

   always_comb begin
      w_stall_next = '0;
      if (r_val && !i_ret) begin
         w_stall_next = (r_stall == c_stall_max) ? r_stall : r_stall + c_stall_one;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_val     <= 1'b0;
         r_data    <= '0;
         r_stall   <= '0;
         r_blocked <= 1'b0;
      end else begin
         r_stall   <= w_stall_next;
         r_blocked <= (w_stall_next >= c_stall_limit);
         case (r_state)
            IDLE: begin
               if (i_avail) begin
                  r_data  <= i_head;
                  r_val   <= 1'b1;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (i_ret) begin
                  if (i_avail) begin
                     r_data <= i_head;
                  end else begin
                     r_val   <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_val   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_val     = r_val;
   assign o_data    = r_data;
   assign o_blocked = r_blocked;

endmodule
`default_nettype wire

// File: rtl/block_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | block_output : router output port, FIFO plus val/ret link driver     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module block_output
   import noc_defs::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DEPTH       = 4,
   parameter int STALL_W     = 8,
   parameter int STALL_LIMIT = 200
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_req,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] Data_in,
   output logic                  val,
   input  logic                  ret,
   output logic [DATA_WIDTH-1:0] Data_out,
   output logic                  empty,
   output logic                  blocked
);

   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_cnt_w-1:0]    r_count;

   logic                  w_in_ready;
   logic                  w_write;
   logic                  w_pop;
   logic                  w_avail;
   logic                  w_val;

   // full refuses writes even when a pop happens in the same cycle
   assign w_in_ready = (r_count != c_full);
   assign w_write    = in_req && w_in_ready;
   assign w_avail    = (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_write) begin
         r_mem[r_wr_ptr] <= Data_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   output_flow_control #(
      .DATA_WIDTH  (DATA_WIDTH),
      .STALL_W     (STALL_W),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_flow (
      .clk       (clk),
      .rst       (rst),
      .i_avail   (w_avail),
      .i_head    (r_mem[r_rd_ptr]),
      .i_ret     (ret),
      .o_pop     (w_pop),
      .o_val     (w_val),
      .o_data    (Data_out),
      .o_blocked (blocked)
   );

   assign in_ready = w_in_ready;
   assign val      = w_val;
   assign empty    = !w_avail && !w_val;

endmodule
`default_nettype wire

// File: tb/tb_block_output.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_block_output : scoreboard bench for the router output port        |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_block_output;

   localparam int DW        = 8;
   localparam int DEPTH     = 4;
   localparam int STALL_W   = 8;
   localparam int LIMIT     = 3;
   localparam int STALL_MAX = (1 << STALL_W) - 1;

   logic          clk;
   logic          rst;
   logic          in_req;
   logic          in_ready;
   logic [DW-1:0] Data_in;
   logic          val;
   logic          ret;
   logic [DW-1:0] Data_out;
   logic          empty;
   logic          blocked;

   int checks = 0;
   int errors = 0;

   // Reference model: the queue holds every accepted flit not yet handed over;
   // m_cnt is the number still in the FIFO (not in the output stage).
   logic [DW-1:0] exp_q[$];
   int            m_cnt   = 0;
   bit            m_val   = 0;
   int            m_stall = 0;

   block_output #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .STALL_W     (STALL_W),
      .STALL_LIMIT (LIMIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_req   (in_req),
      .in_ready (in_ready),
      .Data_in  (Data_in),
      .val      (val),
      .ret      (ret),
      .Data_out (Data_out),
      .empty    (empty),
      .blocked  (blocked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("reset_val", val, 0);
         check("reset_empty", empty, 1);
         check("reset_in_ready", in_ready, 1);
         check("reset_blocked", blocked, 0);
         check("reset_data", Data_out, 0);
         m_cnt   = 0;
         m_val   = 0;
         m_stall = 0;
         exp_q.delete();
      end else begin
         bit wr, pop;
         check("in_ready", in_ready, (m_cnt != DEPTH));
         check("val", val, m_val);
         check("empty", empty, (m_cnt == 0 && !m_val));
         check("blocked", blocked, (m_stall >= LIMIT));
         if (m_val) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_underflow", 1, 0);
            end else begin
               check("data_out", Data_out, exp_q[0]);
            end
         end
         if (val && ret && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
         wr  = in_req && (m_cnt != DEPTH);
         pop = (m_cnt > 0) && (!m_val || ret);
         if (m_val && !ret) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
         else               m_stall = 0;
         m_val = pop || (m_val && !ret);
         m_cnt = m_cnt + int'(wr) - int'(pop);
      end
   end

   task automatic step(input bit req, input logic [DW-1:0] d, input bit rt);
      @(posedge clk);
      #1;
      in_req  = req;
      Data_in = d;
      ret     = rt;
      if (req && rst && m_cnt != DEPTH) exp_q.push_back(d);
   endtask

   initial begin
      rst     = 1'b0;
      in_req  = 1'b0;
      Data_in = '0;
      ret     = 1'b1;
      repeat (3) step(0, 8'h00, 1);
      rst = 1'b1;

      repeat (10) step(0, 8'h00, 1);

      step(1, 8'hA5, 1);
      repeat (4) step(0, 8'h00, 1);

      for (int i = 1; i <= 4; i++) step(1, 8'(i), 1);
      repeat (5) step(0, 8'h00, 1);

      // fill while stalled, then try writing into a full FIFO during a pop
      for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0);
      repeat (4) step(0, 8'h00, 0);
      step(1, 8'h99, 1);
      repeat (8) step(0, 8'h00, 1);

      for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0);
      step(0, 8'h00, 1);
      step(0, 8'h00, 0);
      step(0, 8'h00, 1);
      step(0, 8'h00, 0);
      repeat (4) step(0, 8'h00, 1);

      // asynchronous reset in the middle of a stalled transfer
      for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("async_val", val, 0);
      check("async_empty", empty, 1);
      check("async_in_ready", in_ready, 1);
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);
      rst = 1'b1;
      step(1, 8'h7E, 1);
      repeat (5) step(0, 8'h00, 1);

      // long stall to reach counter saturation
      step(1, 8'h55, 0);
      repeat (270) step(($urandom_range(0, 99) < 50), 8'($urandom), 0);
      repeat (10) step(0, 8'h00, 1);

      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 65));
      end

      repeat (12) step(0, 8'h00, 1);
      @(negedge clk);
      #1;
      check("drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
